// File: rtl/srec_pkg.sv
// -----------------------------------------------------------------------------
// srec_pkg
// Shared definitions for the S-record word parser:
//   - parser state enumeration
//   - ASCII constants for the record marker, record types and line endings
//   - per-record-type helpers (address byte count, data/start record class)
//   - ASCII hex helpers (is_hex / hex_val)
// No ports; imported by srec_hex_nibble and srec_word_parser.
// -----------------------------------------------------------------------------
package srec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TYPE,
    ST_COUNT,
    ST_ADDR,
    ST_DATA,
    ST_CSUM,
    ST_EOL,
    ST_SKIP
  } srec_state_e;

  localparam logic [7:0] CH_S  = 8'h53;  // 'S'
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;

  localparam logic [7:0] CH_T0 = 8'h30;
  localparam logic [7:0] CH_T1 = 8'h31;
  localparam logic [7:0] CH_T2 = 8'h32;
  localparam logic [7:0] CH_T3 = 8'h33;
  localparam logic [7:0] CH_T5 = 8'h35;
  localparam logic [7:0] CH_T7 = 8'h37;
  localparam logic [7:0] CH_T8 = 8'h38;
  localparam logic [7:0] CH_T9 = 8'h39;

  function automatic logic is_type(input logic [7:0] c);
    return (c == CH_T0) || (c == CH_T1) || (c == CH_T2) || (c == CH_T3) ||
           (c == CH_T5) || (c == CH_T7) || (c == CH_T8) || (c == CH_T9);
  endfunction

  // Number of address bytes carried by each record type.
  function automatic logic [2:0] addr_bytes(input logic [7:0] c);
    logic [2:0] n;
    case (c)
      CH_T2, CH_T8: n = 3'd3;
      CH_T3, CH_T7: n = 3'd4;
      default:      n = 3'd2;
    endcase
    return n;
  endfunction

  // Records whose data field is written to memory.
  function automatic logic is_data_type(input logic [7:0] c);
    return (c == CH_T1) || (c == CH_T2) || (c == CH_T3);
  endfunction

  // Records that carry a start (entry) address.
  function automatic logic is_start_type(input logic [7:0] c);
    return (c == CH_T7) || (c == CH_T8) || (c == CH_T9);
  endfunction

  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h41) && (c <= 8'h46)) ||
           ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  // 'A'/'a' have low nibble 1, so letters map to low nibble + 9.
  function automatic logic [3:0] hex_val(input logic [7:0] c);
    logic [3:0] v;
    if ((c >= 8'h30) && (c <= 8'h39)) begin
      v = c[3:0];
    end else if (is_hex(c)) begin
      v = c[3:0] + 4'd9;
    end else begin
      v = 4'd0;
    end
    return v;
  endfunction

endpackage

// File: rtl/srec_hex_nibble.sv
// -----------------------------------------------------------------------------
// srec_hex_nibble
// ASCII to nibble decoder for the character presented on the (already
// registered) UART character output. Decoding is combinational so that the
// parser can act on a character in the cycle it is offered.
// Ports:
//   char_data  in  8  ASCII character
//   char_ready in  1  character valid this cycle
//   nib_valid  out 1  valid character that is a hex digit
//   nib_bad    out 1  valid character that is not a hex digit
//   nib_value  out 4  decoded value (0 when not a hex digit)
// -----------------------------------------------------------------------------
module srec_hex_nibble
  import srec_pkg::*;
(
  input  logic [7:0] char_data,
  input  logic       char_ready,
  output logic       nib_valid,
  output logic       nib_bad,
  output logic [3:0] nib_value
);

  assign nib_valid = char_ready &&  is_hex(char_data);
  assign nib_bad   = char_ready && !is_hex(char_data);
  assign nib_value = hex_val(char_data);

endmodule

// File: rtl/srec_word_parser.sv
// -----------------------------------------------------------------------------
// srec_word_parser
// Parses an ASCII Motorola S-record stream (S0/1/2/3/5/7/8/9) one character
// per char_ready and emits BYTES-wide lane-aligned memory writes with strobes.
// Ports:
//   clock, reset_n (synchronous, active low)
//   char_data/char_ready      character input, no backpressure
//   format_error/checksum_error one-cycle error pulses
//   error_location            record index of the most recent error
//   write_address/data/strobe/enable  word write port (little-endian lanes)
//   start_address/start_valid only when SREC_START_ADDR_EN is defined
// Optional feature macro: SREC_START_ADDR_EN
// -----------------------------------------------------------------------------
module srec_word_parser
  import srec_pkg::*;
#(
  parameter int BYTES  = 4,
  parameter int ADDR_W = 32,
  parameter int LOC_W  = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [7:0]           char_data,
  input  logic                 char_ready,
  output logic                 format_error,
  output logic                 checksum_error,
  output logic [LOC_W-1:0]     error_location,
  output logic [ADDR_W-1:0]    write_address,
  output logic [8*BYTES-1:0]   write_data,
  output logic [BYTES-1:0]     write_strobe,
  output logic                 write_enable
`ifdef SREC_START_ADDR_EN
  ,
  output logic [ADDR_W-1:0]    start_address,
  output logic                 start_valid
`endif
);

  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

  srec_state_e            state_q, state_d;
  logic [7:0]             rtype_q, rtype_d;
  logic                   phase_q, phase_d;       // 1: high nibble captured
  logic [3:0]             hi_nib_q, hi_nib_d;
  logic [7:0]             count_q, count_d;
  logic [7:0]             left_q, left_d;         // bytes left in ADDR/DATA
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [7:0]             sum_q, sum_d;
  logic [LOC_W-1:0]       line_q, line_d;
  logic [8*BYTES-1:0]     acc_word_q, acc_word_d;
  logic [BYTES-1:0]       acc_strb_q, acc_strb_d;
  logic                   fmt_err_q, fmt_err_d;
  logic                   csum_err_q, csum_err_d;
  logic [LOC_W-1:0]       err_loc_q, err_loc_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [8*BYTES-1:0]     wr_data_q, wr_data_d;
  logic [BYTES-1:0]       wr_strb_q, wr_strb_d;
  logic                   wr_en_q, wr_en_d;
`ifdef SREC_START_ADDR_EN
  logic [ADDR_W-1:0]      start_addr_q, start_addr_d;
  logic                   start_valid_q, start_valid_d;
`endif

  logic                   nib_valid, nib_bad;
  logic [3:0]             nib_value;
  logic                   byte_done;
  logic [7:0]             byte_val;
  logic [2:0]             ab;
  logic [7:0]             data_len;
  logic [LANE_W-1:0]      lane;
  logic [BYTES-1:0]       lane_hit;

  srec_hex_nibble u_nib (
    .char_data  (char_data),
    .char_ready (char_ready),
    .nib_valid  (nib_valid),
    .nib_bad    (nib_bad),
    .nib_value  (nib_value)
  );

  assign ab       = addr_bytes(rtype_q);
  assign data_len = count_q - {5'b0, ab} - 8'd1;
  assign byte_val = {hi_nib_q, nib_value};
  assign lane     = (BYTES > 1) ? addr_q[LANE_W-1:0] : '0;

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    assign lane_hit[gi] = (lane == LANE_W'(gi));
  end

  always_comb begin
    state_d    = state_q;
    rtype_d    = rtype_q;
    phase_d    = phase_q;
    hi_nib_d   = hi_nib_q;
    count_d    = count_q;
    left_d     = left_q;
    addr_d     = addr_q;
    sum_d      = sum_q;
    line_d     = line_q;
    acc_word_d = acc_word_q;
    acc_strb_d = acc_strb_q;
    fmt_err_d  = 1'b0;
    csum_err_d = 1'b0;
    err_loc_d  = err_loc_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
    wr_en_d    = 1'b0;
`ifdef SREC_START_ADDR_EN
    start_addr_d  = start_addr_q;
    start_valid_d = 1'b0;
`endif
    byte_done  = 1'b0;

    // Character-level decoding: framing characters and nibble pairing.
    if (char_ready) begin
      case (state_q)
        ST_IDLE: begin
          if (char_data == CH_S) begin
            line_d  = line_q + LOC_W'(1);
            state_d = ST_TYPE;
          end else if ((char_data != CH_CR) && (char_data != CH_LF) &&
                       (char_data != CH_SP)) begin
            fmt_err_d = 1'b1;
            err_loc_d = line_q;
            state_d   = ST_SKIP;
          end
        end
        ST_TYPE: begin
          if (is_type(char_data)) begin
            rtype_d    = char_data;
            phase_d    = 1'b0;
            addr_d     = '0;
            sum_d      = '0;
            acc_word_d = '0;
            acc_strb_d = '0;
            state_d    = ST_COUNT;
          end else begin
            fmt_err_d = 1'b1;
            err_loc_d = line_q;
            state_d   = ST_SKIP;
          end
        end
        ST_COUNT, ST_ADDR, ST_DATA, ST_CSUM: begin
          if (nib_bad) begin
            fmt_err_d = 1'b1;
            err_loc_d = line_q;
            phase_d   = 1'b0;
            state_d   = ST_SKIP;
          end else if (nib_valid && !phase_q) begin
            hi_nib_d = nib_value;
            phase_d  = 1'b1;
          end else if (nib_valid) begin
            phase_d   = 1'b0;
            byte_done = 1'b1;
          end
        end
        ST_EOL: begin
          if ((char_data == CH_CR) || (char_data == CH_LF)) begin
            state_d = ST_IDLE;
          end else begin
            fmt_err_d = 1'b1;
            err_loc_d = line_q;
            state_d   = ST_SKIP;
          end
        end
        default: begin  // ST_SKIP
          if ((char_data == CH_CR) || (char_data == CH_LF)) begin
            state_d = ST_IDLE;
          end
        end
      endcase
    end

    // Byte-level record handling once both nibbles are in.
    if (byte_done) begin
      case (state_q)
        ST_COUNT: begin
          count_d = byte_val;
          sum_d   = byte_val;
          left_d  = {5'b0, ab};
          if (byte_val <= {5'b0, ab}) begin
            fmt_err_d = 1'b1;
            err_loc_d = line_q;
            state_d   = ST_SKIP;
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_ADDR: begin
          addr_d = {addr_q[ADDR_W-9:0], byte_val};
          sum_d  = sum_q + byte_val;
          left_d = left_q - 8'd1;
          if (left_q == 8'd1) begin
            if (data_len == 8'd0) begin
              state_d = ST_CSUM;
            end else begin
              left_d  = data_len;
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          sum_d  = sum_q + byte_val;
          addr_d = addr_q + ADDR_W'(1);
          left_d = left_q - 8'd1;
          if (is_data_type(rtype_q)) begin
            for (int i = 0; i < BYTES; i++) begin
              if (lane_hit[i]) begin
                acc_word_d[8*i +: 8] = byte_val;
                acc_strb_d[i]        = 1'b1;
              end
            end
            // Flush on the top lane or the record's last byte so no word
            // ever carries bytes from two records.
            if (lane_hit[BYTES-1] || (left_q == 8'd1)) begin
              wr_en_d    = 1'b1;
              wr_addr_d  = addr_q & ALIGN_MASK;
              wr_data_d  = acc_word_d;
              wr_strb_d  = acc_strb_d;
              acc_word_d = '0;
              acc_strb_d = '0;
            end
          end
          if (left_q == 8'd1) begin
            state_d = ST_CSUM;
          end
        end
        ST_CSUM: begin
          state_d = ST_EOL;
          if (byte_val != ~sum_q) begin
            csum_err_d = 1'b1;
            err_loc_d  = line_q;
          end
`ifdef SREC_START_ADDR_EN
          else if (is_start_type(rtype_q)) begin
            start_addr_d  = addr_q;
            start_valid_d = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rtype_q    <= '0;
      phase_q    <= 1'b0;
      hi_nib_q   <= '0;
      count_q    <= '0;
      left_q     <= '0;
      addr_q     <= '0;
      sum_q      <= '0;
      line_q     <= '0;
      acc_word_q <= '0;
      acc_strb_q <= '0;
      fmt_err_q  <= 1'b0;
      csum_err_q <= 1'b0;
      err_loc_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      wr_en_q    <= 1'b0;
`ifdef SREC_START_ADDR_EN
      start_addr_q  <= '0;
      start_valid_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rtype_q    <= rtype_d;
      phase_q    <= phase_d;
      hi_nib_q   <= hi_nib_d;
      count_q    <= count_d;
      left_q     <= left_d;
      addr_q     <= addr_d;
      sum_q      <= sum_d;
      line_q     <= line_d;
      acc_word_q <= acc_word_d;
      acc_strb_q <= acc_strb_d;
      fmt_err_q  <= fmt_err_d;
      csum_err_q <= csum_err_d;
      err_loc_q  <= err_loc_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      wr_en_q    <= wr_en_d;
`ifdef SREC_START_ADDR_EN
      start_addr_q  <= start_addr_d;
      start_valid_q <= start_valid_d;
`endif
    end
  end

  assign format_error   = fmt_err_q;
  assign checksum_error = csum_err_q;
  assign error_location = err_loc_q;
  assign write_address  = wr_addr_q;
  assign write_data     = wr_data_q;
  assign write_strobe   = wr_strb_q;
  assign write_enable   = wr_en_q;
`ifdef SREC_START_ADDR_EN
  assign start_address  = start_addr_q;
  assign start_valid    = start_valid_q;
`endif

endmodule

// File: tb/tb_srec_word_parser.sv
// -----------------------------------------------------------------------------
// tb_srec_word_parser
// Directed bench for srec_word_parser (BYTES=4, ADDR_W=32, LOC_W=8).
// Characters are offered back to back; outputs are sampled on the falling
// edge after each character, so an event logged at position i rose one cycle
// after character i. Start-address checks exist only with SREC_START_ADDR_EN.
// -----------------------------------------------------------------------------
module tb_srec_word_parser;

  logic        clock;
  logic        reset_n;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        format_error;
  logic        checksum_error;
  logic [7:0]  error_location;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic        write_enable;
`ifdef SREC_START_ADDR_EN
  logic [31:0] start_address;
  logic        start_valid;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [63:0] wr_addr_log[$];
  logic [63:0] wr_data_log[$];
  logic [63:0] wr_strb_log[$];
  int          wr_pos_log[$];
  int          fe_pos_log[$];
  logic [63:0] fe_loc_log[$];
  int          ce_pos_log[$];
  logic [63:0] ce_loc_log[$];
  int          sv_pos_log[$];
  logic [63:0] sv_addr_log[$];

  srec_word_parser #(
    .BYTES  (4),
    .ADDR_W (32),
    .LOC_W  (8)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .char_data      (char_data),
    .char_ready     (char_ready),
    .format_error   (format_error),
    .checksum_error (checksum_error),
    .error_location (error_location),
    .write_address  (write_address),
    .write_data     (write_data),
    .write_strobe   (write_strobe),
    .write_enable   (write_enable)
`ifdef SREC_START_ADDR_EN
    ,
    .start_address  (start_address),
    .start_valid    (start_valid)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr_log.delete(); wr_data_log.delete(); wr_strb_log.delete(); wr_pos_log.delete();
    fe_pos_log.delete(); fe_loc_log.delete(); ce_pos_log.delete(); ce_loc_log.delete();
    sv_pos_log.delete(); sv_addr_log.delete();
  endtask

  // Offer one record, logging every output event with its character position.
  task automatic send_str(input string label, input string s);
    clear_logs();
    for (int i = 0; i < s.len(); i++) begin
      char_data  = s[i];
      char_ready = 1'b1;
      @(negedge clock);
      if (write_enable) begin
        wr_addr_log.push_back(64'(write_address));
        wr_data_log.push_back(64'(write_data));
        wr_strb_log.push_back(64'(write_strobe));
        wr_pos_log.push_back(i);
      end
      if (format_error) begin
        fe_pos_log.push_back(i);
        fe_loc_log.push_back(64'(error_location));
      end
      if (checksum_error) begin
        ce_pos_log.push_back(i);
        ce_loc_log.push_back(64'(error_location));
      end
`ifdef SREC_START_ADDR_EN
      if (start_valid) begin
        sv_pos_log.push_back(i);
        sv_addr_log.push_back(64'(start_address));
      end
`endif
    end
    char_ready = 1'b0;
    char_data  = 8'h00;
    $display("record %s: writes=%0d format_err=%0d checksum_err=%0d start=%0d",
             label, wr_addr_log.size(), fe_pos_log.size(), ce_pos_log.size(),
             sv_pos_log.size());
  endtask

  task automatic check_wr(input string tag, input int k, input logic [63:0] addr,
                          input logic [63:0] data, input logic [63:0] strb, input int pos);
    if (wr_addr_log.size() > k) begin
      check({tag, "_addr"}, wr_addr_log[k], addr);
      check({tag, "_data"}, wr_data_log[k], data);
      check({tag, "_strb"}, wr_strb_log[k], strb);
      check({tag, "_pos"},  64'(wr_pos_log[k]), 64'(pos));
    end else begin
      check({tag, "_present"}, 64'(wr_addr_log.size()), 64'(k + 1));
    end
  endtask

  task automatic check_fe(input string tag, input int pos, input logic [63:0] loc);
    check({tag, "_nfe"}, 64'(fe_pos_log.size()), 64'd1);
    if (fe_pos_log.size() > 0) begin
      check({tag, "_fe_pos"}, 64'(fe_pos_log[0]), 64'(pos));
      check({tag, "_fe_loc"}, fe_loc_log[0], loc);
    end
  endtask

  task automatic check_ce(input string tag, input int pos, input logic [63:0] loc);
    check({tag, "_nce"}, 64'(ce_pos_log.size()), 64'd1);
    if (ce_pos_log.size() > 0) begin
      check({tag, "_ce_pos"}, 64'(ce_pos_log[0]), 64'(pos));
      check({tag, "_ce_loc"}, ce_loc_log[0], loc);
    end
  endtask

  task automatic check_counts(input string tag, input int nwr, input int nfe, input int nce);
    check({tag, "_nwr"}, 64'(wr_addr_log.size()), 64'(nwr));
    check({tag, "_nfe"}, 64'(fe_pos_log.size()), 64'(nfe));
    check({tag, "_nce"}, 64'(ce_pos_log.size()), 64'(nce));
  endtask

  initial begin
    reset_n    = 1'b0;
    char_ready = 1'b0;
    char_data  = 8'h00;
    repeat (3) @(negedge clock);

    // Reset state
    check("rst_we",   64'(write_enable),   64'd0);
    check("rst_fe",   64'(format_error),   64'd0);
    check("rst_ce",   64'(checksum_error), 64'd0);
    check("rst_loc",  64'(error_location), 64'd0);
    check("rst_addr", 64'(write_address),  64'd0);
    check("rst_data", 64'(write_data),     64'd0);
    check("rst_strb", 64'(write_strobe),   64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Record 1: full word at 0
    send_str("A", "S107000001020304EE\r\n");
    check_counts("A", 1, 0, 0);
    check_wr("A_w0", 0, 64'h0, 64'h04030201, 64'hF, 15);

    // Record 2: S2, lowercase digits, two bytes at 0x1000
    send_str("B", "S206001000aabb84\n");
    check_counts("B", 1, 0, 0);
    check_wr("B_w0", 0, 64'h1000, 64'h0000BBAA, 64'h3, 13);

    // Record 3: bad checksum, write still emitted
    send_str("C", "S107000001020304EF\r\n");
    check_wr("C_w0", 0, 64'h0, 64'h04030201, 64'hF, 15);
    check_ce("C", 17, 64'd3);
    check("C_nfe", 64'(fe_pos_log.size()), 64'd0);

    // Record 4: non-hex in count field, rest of line ignored
    send_str("D", "S1G7000000\r\n");
    check_counts("D", 0, 1, 0);
    check_fe("D", 2, 64'd4);

    // Record 5: crosses a word boundary
    send_str("E", "S1070002112233444C\n");
    check_counts("E", 2, 0, 0);
    check_wr("E_w0", 0, 64'h0, 64'h22110000, 64'hC, 11);
    check_wr("E_w1", 1, 64'h4, 64'h00004433, 64'h3, 15);
    check("E_loc_held", 64'(error_location), 64'd4);

    // Records 6,7: S0 and S5 are checked but not written
    send_str("F", "S00600004844521B\r\n");
    check_counts("F", 0, 0, 0);
    send_str("G", "S5030003F9\n");
    check_counts("G", 0, 0, 0);

    // Record 8: S9 start record
    send_str("H", "S9031234B6\n");
    check_counts("H", 0, 0, 0);
`ifdef SREC_START_ADDR_EN
    check("H_nsv", 64'(sv_pos_log.size()), 64'd1);
    if (sv_pos_log.size() > 0) begin
      check("H_sv_pos",  64'(sv_pos_log[0]), 64'd9);
      check("H_sv_addr", sv_addr_log[0], 64'h1234);
    end
`endif

    // Record 9: count too small for the address
    send_str("I", "S1020000FD\n");
    check_counts("I", 0, 1, 0);
    check_fe("I", 3, 64'd9);

    // Record 10: junk where end of line is expected
    send_str("J", "S5030003F9X\n");
    check_fe("J", 10, 64'd10);
    check("J_nce", 64'(ce_pos_log.size()), 64'd0);

    // Garbage while idle
    send_str("K", "Z\n");
    check("K_nfe", 64'(fe_pos_log.size()), 64'd1);
    if (fe_pos_log.size() > 0) check("K_fe_pos", 64'(fe_pos_log[0]), 64'd0);

    // Record 11: illegal type
    send_str("L", "S4\n");
    check_fe("L", 1, 64'd11);

    // Reset mid-DATA with a character offered during reset
    send_str("M_part", "S107000001");
    check("M_part_nwr", 64'(wr_addr_log.size()), 64'd0);
    reset_n    = 1'b0;
    char_data  = 8'h53;
    char_ready = 1'b1;
    @(negedge clock);
    char_ready = 1'b0;
    check("M_rst_loc",  64'(error_location), 64'd0);
    check("M_rst_addr", 64'(write_address),  64'd0);
    check("M_rst_strb", 64'(write_strobe),   64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    send_str("M", "S10400215500\n");
    check("M_nwr", 64'(wr_addr_log.size()), 64'd1);
    check_wr("M_w0", 0, 64'h20, 64'h00005500, 64'h2, 9);
    check_ce("M", 11, 64'd1);

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/srec_word_parser.md
# srec_word_parser

Parametrised successor to the byte-wide S-record parser. It consumes an ASCII Motorola S-record stream, one character per `char_ready` pulse, and accepts S0/S1/S2/S3/S5/S7/S8/S9 records. Data bytes are packed into `BYTES`-wide, lane-aligned memory writes with byte strobes. The block sits between the UART receiver's character output and the on-chip memory write port of the loader.

## Interface
Parameters:
- `BYTES`, default 4: write word width in bytes; legal values 1, 2, 4, 8.
- `ADDR_W`, default 32: width of `write_address` (byte address); must be ≥ 16.
- `LOC_W`, default 8: width of `error_location`, which is the record (line) counter.

Ports:
- `clock`  in  1  — single clock.
- `reset_n`  in  1  — synchronous, active-low reset.
- `char_data`  in  8  — ASCII character.
- `char_ready`  in  1  — `char_data` valid this cycle; at most one character per cycle.
- `format_error`  out  1  — one-cycle pulse on a malformed record.
- `checksum_error`  out  1  — one-cycle pulse on a checksum mismatch.
- `error_location`  out  `LOC_W`  — 1-based index of the record in error (wraps modulo 2^LOC_W).
- `write_address`  out  `ADDR_W`  — word-aligned byte address; low log2(`BYTES`) bits are 0.
- `write_data`  out  8·`BYTES`  — byte at address A is in lane A mod `BYTES` (little-endian lanes).
- `write_strobe`  out  `BYTES`  — per-lane enable.
- `write_enable`  out  1  — one-cycle write pulse.

## Operation
- Reset value of every output is 0. Reset clears the state, the line counter and any partial word; a partially parsed record is discarded.
- States:
  - `IDLE`: wait for 'S'. CR, LF and space are ignored. Any other character → `format_error`, then `SKIP`.
  - `TYPE`: accept '0','1','2','3','5','7','8','9'. Any other character → `format_error`.
  - `COUNT`: 2 hex digits.
  - `ADDR`: 4, 6 or 8 hex digits for S0/S1/S5/S9, S2/S8 and S3/S7 respectively. Address bits above `ADDR_W` are dropped.
  - `DATA`: (count − address bytes − 1) bytes.
  - `CSUM`: 2 hex digits.
  - `EOL`: expects CR or LF, then returns to `IDLE`.
  - `SKIP`: discard characters until CR/LF, then `IDLE`.
- Hex digits accepted: 0-9, A-F, a-f. Any non-hex character in `COUNT`/`ADDR`/`DATA`/`CSUM` → `format_error`, `SKIP`. A non-CR/LF character in `EOL` → `format_error`, `SKIP`.
- If count < address bytes + 1 → `format_error` when the count completes.
- Checksum: 8-bit sum of count, address and data bytes. Expected value is the one's complement of that sum. A mismatch pulses `checksum_error` on the cycle after the second checksum digit.
- The line counter increments on each 'S' accepted in `IDLE`. `error_location` holds the last erroring record's index until the next error.
- Only S1/S2/S3 data is written. S0 and S5 are checksummed and discarded. S7/S8/S9 are checksummed; start-address handling is covered under Configuration.
- Packing:
  - Completing a data byte sets its lane in the accumulator and its strobe bit.
  - A word is emitted when the byte lands in lane `BYTES`−1, or when it is the record's last data byte.
  - Words never span records.
  - The address increments by 1 per byte; overflow wraps modulo 2^`ADDR_W`.
- Data is written speculatively. A checksum error does not retract writes already emitted.
- `format_error` and `checksum_error` are never asserted in the same cycle.

## Timing
- All outputs are registered.
- `write_enable` rises one cycle after the `char_ready` cycle carrying the second nibble of the word's final byte.
- Error pulses rise one cycle after the offending character.
- Back-to-back `char_ready` every cycle is supported with no stall. There is no backpressure, so the downstream memory must accept one write per cycle.
- If `reset_n` is low in the same cycle as `char_ready`, the character is dropped.

## Configuration
- `SREC_START_ADDR_EN`:
  - Defined: adds outputs `start_address` [`ADDR_W`] and `start_valid` (reset 0). A checksum-correct S7/S8/S9 loads `start_address` and pulses `start_valid` one cycle after its second checksum digit.
  - Undefined: these ports do not exist, and S7/S8/S9 are checksummed only.

## Structure
- Shared package `srec_pkg`:
  - state enum;
  - record-type character constants;
  - address-byte count per type;
  - `hex_val`/`is_hex` constants.
- Sub-module `srec_hex_nibble`: a registered-input ASCII→nibble decoder with a valid flag.
- The packing accumulator lives in the top level.

## Test plan
- `BYTES`=4, stream "S10700000102030 4EE\r\n" without the space → one write: address 0x0, data 0x04030201, strobe 4'b1111; no error pulses.
- "S206001000AABB84\n" → write address 0x1000, data lanes 0/1 = AA/BB, strobe 4'b0011.
- "S1070000010203 04EF\n" with the space removed (wrong checksum) → the same write, then `checksum_error` pulse with `error_location`=1.
- "S1G7..." as the second record → `format_error` on the 'G' cycle+1 with `error_location`=2; the rest of the line is ignored, and the next valid record parses normally.
- With `SREC_START_ADDR_EN`, "S9031234B6\n" → `start_valid` pulse with `start_address`=0x1234; no write.
- `reset_n` low mid-DATA, then a fresh S1 record → no stale word emitted, and the line counter restarts at 1.
